// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM duty cycle in percent with timeout (stuck) and overrun reporting.
// Optional build macro PWM_CAPTURE_GLITCH_FILTER_EN inserts a 3-sample glitch filter after the synchronizer.
module pwm_capture #(
   parameter int CNT_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       pwm_in,
   output logic [6:0] duty,
   output logic       duty_valid,
   output logic       stuck,
   output logic       overrun
);
   typedef enum logic [1:0] {WAIT_FIRST, MEASURE, DIVIDE} state_t;
   localparam logic [CNT_W-1:0] MAX = '1;
   state_t r_state, w_nxt;
   logic r_meta, r_sync, r_prev;
   logic w_lvl, w_rise, w_fall, w_tout, w_last, w_ge;
   logic [CNT_W-1:0] r_pcnt, r_hcnt;
   logic [CNT_W+6:0] r_rem, r_div, w_diff, w_prod;
   logic [5:0] r_q;
   logic [2:0] r_it;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {r_meta, r_sync} <= '0;
      else {r_meta, r_sync} <= {pwm_in, r_meta};
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic r_s1, r_s2, r_filt;
   // Level follows sync only once three consecutive samples agree.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {r_s1, r_s2, r_filt} <= '0;
      else {r_s1, r_s2, r_filt} <= {r_sync, r_s1, w_lvl};
   assign w_lvl = (r_sync == r_s1 && r_s1 == r_s2) ? r_sync : r_filt;
`else
   assign w_lvl = r_sync;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_prev <= 1'b0;
      else r_prev <= w_lvl;
   assign w_rise = w_lvl & ~r_prev;
   assign w_fall = ~w_lvl & r_prev;
   assign w_tout = ena && r_state == MEASURE && !w_rise && r_pcnt == MAX;
   assign w_last = r_it == 3'd6;
   assign w_ge   = r_rem >= r_div;
   assign w_diff = r_rem - r_div;
   assign w_prod = {7'd0, r_hcnt} * (CNT_W+7)'(100);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= WAIT_FIRST;
      else r_state <= w_nxt;
   always_comb begin
      w_nxt = r_state;
      if (!ena) w_nxt = WAIT_FIRST;
      else if (r_state == WAIT_FIRST) w_nxt = w_rise ? MEASURE : WAIT_FIRST;
      else if (r_state == MEASURE) w_nxt = w_rise ? DIVIDE : (w_tout ? WAIT_FIRST : MEASURE);
      else w_nxt = w_last ? MEASURE : DIVIDE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt     <= '0;
         r_hcnt     <= '0;
         r_rem      <= '0;
         r_div      <= '0;
         r_q        <= '0;
         r_it       <= '0;
         duty       <= '0;
         duty_valid <= 1'b0;
         stuck      <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         duty_valid <= 1'b0;
         overrun    <= 1'b0;
         if (w_rise || w_fall) stuck <= 1'b0;
         if (!ena || (r_state == WAIT_FIRST && !w_rise)) begin
            r_pcnt <= '0;
            r_hcnt <= '0;
         end else if (w_rise) begin
            r_pcnt <= CNT_W'(1);
            r_hcnt <= CNT_W'(1);
         end else if (r_pcnt != MAX) begin
            r_pcnt <= r_pcnt + CNT_W'(1);
            r_hcnt <= r_hcnt + CNT_W'(w_lvl);
         end
         if (w_tout) begin
            stuck      <= 1'b1;
            duty       <= w_lvl ? 7'd100 : 7'd0;
            duty_valid <= 1'b1;
         end
         // Divisor starts at P<<6: the quotient never exceeds 100, so 7 restoring steps suffice.
         if (ena && r_state == MEASURE && w_rise) begin
            r_rem <= w_prod;
            r_div <= {1'b0, r_pcnt, 6'b0};
            r_q   <= '0;
            r_it  <= '0;
         end
         if (ena && r_state == DIVIDE) begin
            if (w_rise) overrun <= 1'b1;
            r_it  <= r_it + 3'd1;
            r_q   <= {r_q[4:0], w_ge};
            r_rem <= w_ge ? w_diff : r_rem;
            r_div <= r_div >> 1;
            if (w_last) begin
               duty       <= {r_q, w_ge};
               duty_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and randomized checks of pwm_capture against an event-level duty model.
module tb_pwm_capture;
   localparam int CNT_W = 12;
   localparam int MAXV = (1 << CNT_W) - 1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int SHORT = 3;
`else
   localparam int SHORT = 2;
`endif
   logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, pwm_in = 1'b0;
   logic [6:0] duty;
   logic duty_valid, stuck, overrun;
   int n_cmp = 0, n_bad = 0, n_ovr = 0, exp_ovr = 0;
   int hi_q[$], lo_q[$], exp_q[$], got_q[$];

   pwm_capture #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_in),
      .duty(duty), .duty_valid(duty_valid), .stuck(stuck), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (duty_valid) got_q.push_back(int'(duty));
      if (overrun) n_ovr++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic v, input int n);
      repeat (n) begin
         @(negedge clk);
         pwm_in = v;
      end
   endtask

   task automatic clear();
      got_q.delete();
      hi_q.delete();
      lo_q.delete();
      n_ovr = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ena = 1'b1;
      pwm_in = 1'b0;
      clk_n(3);
      clear();
      rst_n = 1'b1;
      clk_n(3);
   endtask

   task automatic add(input int h, input int l);
      hi_q.push_back(h);
      lo_q.push_back(l);
   endtask

   // Each rising edge closes the previous period; it is reported unless it lands
   // within 7 cycles of the last reported edge (divide busy), in which case it overruns.
   task automatic model();
      int t = 0, tacc = -100;
      exp_q.delete();
      exp_ovr = 0;
      for (int k = 0; k < hi_q.size(); k++) begin
         if (k > 0 && t - tacc <= 7) exp_ovr++;
         else if (k > 0) begin
            exp_q.push_back(hi_q[k-1] * 100 / (hi_q[k-1] + lo_q[k-1]));
            tacc = t;
         end
         t += hi_q[k] + lo_q[k];
      end
   endtask

   task automatic run_seq(input string tag);
      for (int k = 0; k < hi_q.size(); k++) begin
         drive(1'b1, hi_q[k]);
         drive(1'b0, lo_q[k]);
      end
      clk_n(30);
      model();
      chk({tag, " count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s duty[%0d]", tag, i), i < got_q.size() ? got_q[i] : -1, exp_q[i]);
      chk({tag, " overruns"}, n_ovr, exp_ovr);
   endtask

   initial begin
      clk_n(3);
      chk("rst duty", int'(duty), 0);
      chk("rst duty_valid", int'(duty_valid), 0);
      chk("rst stuck", int'(stuck), 0);
      chk("rst overrun", int'(overrun), 0);

      do_reset();
      repeat (5) add(127, 129);
      run_seq("p256h127");

      do_reset();
      repeat (3) add(63, 193);
      repeat (3) add(191, 65);
      run_seq("p256h63to191");

      do_reset();
      repeat (12) add(SHORT, SHORT);
      run_seq("short period");

      do_reset();
      repeat (40) add(int'($urandom_range(40, 3)), int'($urandom_range(40, 3)));
      run_seq("random");

      do_reset();
      add(100, 100);
      add(50, 20);
      run_seq("pre-timeout");
      clk_n(MAXV - 120);
      chk("stuck before timeout", int'(stuck), 0);
      clk_n(40);
      chk("stuck low line", int'(stuck), 1);
      chk("timeout low count", got_q.size(), 2);
      chk("timeout low duty", int'(duty), 0);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      drive(1'b1, 1);
      drive(1'b0, 20);
      chk("glitch stuck", int'(stuck), 1);
      chk("glitch overrun", n_ovr, 0);
      chk("glitch count", got_q.size(), 2);
`endif
      drive(1'b1, 20);
      chk("stuck cleared", int'(stuck), 0);
      clk_n(MAXV);
      chk("stuck high line", int'(stuck), 1);
      chk("timeout high count", got_q.size(), 3);
      chk("timeout high duty", int'(duty), 100);

      do_reset();
      add(20, 20);
      add(20, 20);
      run_seq("pre-reset");
      drive(1'b1, 6);
      #2 rst_n = 1'b0;
      #1;
      chk("mid-divide rst duty", int'(duty), 0);
      chk("mid-divide rst duty_valid", int'(duty_valid), 0);
      chk("mid-divide rst stuck", int'(stuck), 0);
      chk("mid-divide rst overrun", int'(overrun), 0);
      pwm_in = 1'b0;
      clear();
      clk_n(3);
      rst_n = 1'b1;
      clk_n(3);
      add(20, 20);
      add(20, 20);
      run_seq("post-reset");

      do_reset();
      add(30, 30);
      add(10, 30);
      run_seq("pre-abort");
      drive(1'b1, 6);
      ena = 1'b0;
      clk_n(20);
      chk("abort count", got_q.size(), 1);
      chk("abort duty", int'(duty), 50);
      ena = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
